// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                    |
// | Description : Instruction-fetch stage. Holds the 8-bit byte-addressed PC,   |
// |               drives the instruction memory address, and registers the     |
// |               returned 32-bit word together with PC + PC_STEP for the       |
// |               IF/ID pipeline register. Supports stall, branch redirect      |
// |               with a one-slot bubble, and optional halt detection.          |
// | Option      : FETCH_HALT_DETECT_EN - when defined, an opcode field equal to |
// |               HALT_OP parks the stage in HALT until a branch redirect.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                       |
// |   clk_IF           in   1   stage clock, rising edge                        |
// |   rst_n_IF         in   1   asynchronous active-low reset                   |
// |   stall_IF         in   1   freeze PC and outputs                           |
// |   branch_taken_IF  in   1   redirect request (wins over stall)              |
// |   branch_target_IF in   8   redirect byte address, bits [1:0] ignored       |
// |   imem_data_IF     in  32   instruction memory read data (async read)       |
// |   imem_addr_IF     out  8   current PC                                      |
// |   instruction_IF   out 32   registered fetched instruction                  |
// |   nextInst_IF      out  8   registered fetch address + PC_STEP              |
// |   valid_IF         out  1   instruction_IF holds a real instruction         |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PC_STEP  = 8'd4,
  parameter logic [5:0] HALT_OP  = 6'h3F
) (
  input  logic        clk_IF,
  input  logic        rst_n_IF,
  input  logic        stall_IF,
  input  logic        branch_taken_IF,
  input  logic [7:0]  branch_target_IF,
  input  logic [31:0] imem_data_IF,
  output logic [7:0]  imem_addr_IF,
  output logic [31:0] instruction_IF,
  output logic [7:0]  nextInst_IF,
  output logic        valid_IF
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_next;
  logic        r_valid;

  state_t      w_state_nxt;
  logic [7:0]  w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [7:0]  w_next_nxt;
  logic        w_valid_nxt;

  logic [7:0]  w_pc_inc;
  logic [7:0]  w_branch_pc;

  // 8-bit modulo add: 8'hFC + 4 wraps to 8'h00 with no flag.
  assign w_pc_inc    = r_pc + PC_STEP;
  assign w_branch_pc = {branch_target_IF[7:2], 2'b00};

`ifdef FETCH_HALT_DETECT_EN
  logic       w_is_halt;
  logic [1:0] w_unused_tgt_lsb;
  assign w_is_halt        = (imem_data_IF[31:26] == HALT_OP);
  assign w_unused_tgt_lsb = branch_target_IF[1:0];
`else
  // Without halt detection the opcode compare is not built; these sinks keep
  // the ignored target bits and the idle parameter visibly accounted for.
  logic [7:0] w_unused_bits;
  assign w_unused_bits = {branch_target_IF[1:0], HALT_OP};
`endif

  always_ff @(posedge clk_IF or negedge rst_n_IF) begin
    if (!rst_n_IF) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_next  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_next  <= w_next_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_next_nxt  = r_next;
    w_valid_nxt = r_valid;

    case (r_state)
      // Single bubble slot after reset; stall and branch are not sampled.
      S_IDLE: begin
        w_instr_nxt = 32'h0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        if (branch_taken_IF) begin
          w_pc_nxt    = w_branch_pc;
          w_instr_nxt = 32'h0;
          w_next_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
        end else if (!stall_IF) begin
          w_instr_nxt = imem_data_IF;
          w_next_nxt  = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
`ifdef FETCH_HALT_DETECT_EN
          // The halt word itself is delivered; PC parks on its address.
          if (w_is_halt) begin
            w_pc_nxt    = r_pc;
            w_state_nxt = S_HALT;
          end
`endif
        end
      end

`ifdef FETCH_HALT_DETECT_EN
      // Only a redirect leaves HALT; stall is irrelevant here.
      S_HALT: begin
        w_instr_nxt = 32'h0;
        w_next_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        if (branch_taken_IF) begin
          w_pc_nxt    = w_branch_pc;
          w_state_nxt = S_RUN;
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr_IF   = r_pc;
  assign instruction_IF = r_instr;
  assign nextInst_IF    = r_next;
  assign valid_IF       = r_valid;

endmodule
`default_nettype wire
